aurora_tx_arbiter: RTL and testbench
====================================

// Module: aurora_tx_arbiter
// PURPOSE
// - Packet-level round-robin arbiter sharing the single 32-bit AXI-stream TX port of the Aurora link
//   (axiTxT*, auUserClk domain, feeding the 32->64 upconverter) between NREQ packet sources.
// - Holds the grant from first beat to tlast; never interleaves packets.
// - Watchdog terminates a packet whose owner stalls mid-packet; the link never hangs.
// PARAMETERS
// - NREQ            4             number of requesters, 2..16
// - ID_WIDTH        2             width of grantId; NREQ <= 2**ID_WIDTH
// - TIMEOUT_CYCLES  16'd1024      idle-source cycles before abort; 0 disables the watchdog
// - ABORT_WORD      32'hDEADBEEF  data of the forced terminating beat
// PORTS
// - auUserClk    in   1          Aurora user clock; sole clock
// - resetN       in   1          synchronous, active-low reset
// - sTdata       in   32*NREQ    requester data; requester i uses [32*i+31:32*i]
// - sTvalid      in   NREQ       requester valid
// - sTlast       in   NREQ       requester last
// - sTready      out  NREQ       requester ready
// - mTdata       out  32         to link axiTxTdata
// - mTvalid      out  1          to link axiTxTvalid
// - mTlast       out  1          to link axiTxTlast
// - mTready      in   1          from link axiTxTready
// - grantId      out  ID_WIDTH   index of the current/last granted requester
// - busy         out  1          high in XFER or ABORT
// - timeoutErr   out  1          sticky; set on every abort
// - timeoutClr   in   1          clears timeoutErr; set wins if both occur in the same cycle
// BEHAVIOUR
// - Reset (resetN=0 at an auUserClk edge): state=IDLE, grantId=0, rrPtr=0, timeoutErr=0,
//   wdCnt=0. Outputs while in reset: sTready=0, mTvalid=0, mTlast=0, mTdata=0.
// - IDLE:
//   - mTvalid=0, all sTready=0.
//   - If any sTvalid: pick the first set bit searching rrPtr, rrPtr+1, ... mod NREQ.
//   - Register grantId=winner and rrPtr=(winner+1) mod NREQ; go to XFER.
//   - Grant latency is 1 cycle. Exactly one bubble cycle follows every packet.
// - XFER, with g=grantId:
//   - mTdata=sTdata[g], mTvalid=sTvalid[g], mTlast=sTlast[g]; these are combinational.
//   - sTready[g]=mTready; all other sTready=0. The path adds zero cycles of latency.
//   - A beat is accepted when mTvalid & mTready.
//   - An accepted beat with mTlast=1 returns to IDLE.
//   - A single-beat packet is legal.
//   - Grant is held for any packet length; there is no length limit.
// - Watchdog (XFER only):
//   - wdCnt increments each cycle sTvalid[g]=0.
//   - wdCnt clears on any cycle sTvalid[g]=1; backpressure (mTready=0) never counts.
//   - wdCnt is 16-bit and saturates.
//   - When wdCnt==TIMEOUT_CYCLES-1 and sTvalid[g]=0, go to ABORT next cycle.
// - ABORT:
//   - mTvalid=1, mTdata=ABORT_WORD, mTlast=1, all sTready=0.
//   - On mTready go to IDLE and set timeoutErr.
//   - The stalled requester's remaining beats later arrive as a new packet; discarding them is its job.
// - wdCnt clears on every entry to XFER.
// - Simultaneous events:
//   - A requester raising sTvalid in the cycle its grant is lost to abort waits for IDLE arbitration.
//   - In the same IDLE cycle where requesters are pending, the arbiter always grants; IDLE is never held.
// - Reset mid-packet: drops the grant immediately with no tlast. The link upconverter/MGT share
//   this reset domain and flush the partial packet.
// - AXI rule: once mTvalid=1 in ABORT, mTdata/mTlast stay stable until accepted.
//   In XFER, stability is inherited from the requester.
// CONFIGURATION
// - AURORA_TX_ARB_STATS_EN defined: adds output pktCount (16*NREQ).
//   - Counter i increments on each accepted tlast beat of requester i and wraps at 16'hFFFF->0.
//   - ABORT beats are not counted.
//   - pktCount clears to 0 on reset.
// - AURORA_TX_ARB_STATS_EN undefined: the port and its counters are absent. All other behaviour is identical.
// TESTING
// - Req0 sends a 3-beat packet (0x10,0x11,0x12), mTready=1
//   -> mTvalid seen 1 cycle after sTvalid; 3 beats out, tlast on 0x12; grantId=0; then 1 idle cycle.
// - Req0..3 all valid continuously, 2-beat packets
//   -> grant order 0,1,2,3,0,...; no packet interleave; each packet 3 cycles (2 beats + bubble).
// - Req1 mid-packet with mTready toggling 1,0,0,1: no beat lost or duplicated; sTready[1] tracks mTready; others 0.
// - TIMEOUT_CYCLES=8, req2 drops sTvalid after beat 1
//   -> after 8 idle cycles, ABORT beat 0xDEADBEEF with tlast; timeoutErr=1; next grant proceeds.
//   - timeoutClr then clears timeoutErr.
// - Hold mTready=0 for 5000 cycles with req0 valid mid-packet -> no abort, timeoutErr stays 0.
// - resetN=0 for 1 cycle mid-packet on req3 -> next cycle mTvalid=0, sTready=0, grantId=0;
//   with STATS_EN, pktCount=0 and a completed packet then shows pktCount[3]=1.

Source files
------------

// File: rtl/aurora_tx_arbiter.sv
// aurora_tx_arbiter: packet-level round-robin arbiter with stall watchdog for the Aurora TX stream.
// Define AURORA_TX_ARB_STATS_EN to add per-requester packet counters on pktCount.
module aurora_tx_arbiter #(
  parameter int          NREQ           = 4,
  parameter int          ID_WIDTH       = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] ABORT_WORD     = 32'hDEADBEEF
) (
  input  logic                 auUserClk,
  input  logic                 resetN,
  input  logic [32*NREQ-1:0]   sTdata,
  input  logic [NREQ-1:0]      sTvalid,
  input  logic [NREQ-1:0]      sTlast,
  output logic [NREQ-1:0]      sTready,
  output logic [31:0]          mTdata,
  output logic                 mTvalid,
  output logic                 mTlast,
  input  logic                 mTready,
  output logic [ID_WIDTH-1:0]  grantId,
  output logic                 busy,
  output logic                 timeoutErr,
  input  logic                 timeoutClr,
  output logic [1:0]           dbgState
`ifdef AURORA_TX_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]   pktCount
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [15:0]         wd_cnt;

  logic [31:0]         g_data;
  logic                g_valid;
  logic                g_last;
  logic                any_req;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                abort_done;
  logic                wd_expire;

  always_comb begin
    g_data  = sTdata[32*grantId +: 32];
    g_valid = sTvalid[grantId];
    g_last  = sTlast[grantId];
  end

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && sTvalid[(int'(rr_ptr) + k) % NREQ]) begin
        any_req = 1'b1;
        winner  = ID_WIDTH'((int'(rr_ptr) + k) % NREQ);
      end
    end
    next_ptr = ID_WIDTH'((int'(winner) + 1) % NREQ);
  end

  // Handshake: a beat moves on mTvalid & mTready. In XFER only the granted source
  // sees sTready, mirroring mTready, so valid/ready/data pass through with no register.
  always_comb begin
    sTready = '0;
    mTvalid = 1'b0;
    mTlast  = 1'b0;
    mTdata  = '0;
    if (resetN) begin
      case (state)
        ST_XFER: begin
          mTdata           = g_data;
          mTvalid          = g_valid;
          mTlast           = g_last;
          sTready[grantId] = mTready;
        end
        ST_ABORT: begin
          mTdata  = ABORT_WORD;
          mTvalid = 1'b1;
          mTlast  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign abort_done = (state == ST_ABORT) && mTready;
  assign wd_expire  = (TIMEOUT_CYCLES != 16'd0) && (wd_cnt == TIMEOUT_CYCLES - 16'd1);
  assign busy       = (state == ST_XFER) || (state == ST_ABORT);
  assign dbgState   = state;

  always_ff @(posedge auUserClk) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      grantId    <= '0;
      rr_ptr     <= '0;
      wd_cnt     <= '0;
      timeoutErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grantId <= winner;
            rr_ptr  <= next_ptr;
            wd_cnt  <= '0;
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Only a silent owner ages the watchdog; link backpressure never does.
          if (g_valid) begin
            wd_cnt <= '0;
            if (mTready && g_last) state <= ST_IDLE;
          end else begin
            if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
            if (wd_expire) state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (mTready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (abort_done)      timeoutErr <= 1'b1;
      else if (timeoutClr) timeoutErr <= 1'b0;
    end
  end

`ifdef AURORA_TX_ARB_STATS_EN
  always_ff @(posedge auUserClk) begin
    if (!resetN) begin
      pktCount <= '0;
    end else if ((state == ST_XFER) && g_valid && g_last && mTready) begin
      pktCount[16*grantId +: 16] <= pktCount[16*grantId +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// tb_aurora_tx_arbiter: directed and randomized checks of aurora_tx_arbiter against a
// packet-level round-robin model (expected beat queue built from per-source packet lists).
module tb_aurora_tx_arbiter;
  localparam int          NREQ     = 4;
  localparam int          ID_WIDTH = 2;
  localparam int          W        = NREQ + ID_WIDTH + 33;
  localparam logic [15:0] TMO      = 16'd8;
  localparam logic [31:0] ABORT_W  = 32'hDEADBEEF;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [32*NREQ-1:0]  s_tdata;
  logic [NREQ-1:0]     s_tvalid;
  logic [NREQ-1:0]     s_tlast;
  logic [NREQ-1:0]     s_tready;
  logic [31:0]         m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready;
  logic [ID_WIDTH-1:0] grant_id;
  logic                busy;
  logic                timeout_err;
  logic                timeout_clr;
  logic [1:0]          dbg_state;
`ifdef AURORA_TX_ARB_STATS_EN
  logic [16*NREQ-1:0]  pkt_count;
`endif

  always #5 clk = ~clk;

  aurora_tx_arbiter #(
    .NREQ(NREQ), .ID_WIDTH(ID_WIDTH), .TIMEOUT_CYCLES(TMO), .ABORT_WORD(ABORT_W)
  ) dut (
    .auUserClk(clk), .resetN(reset_n),
    .sTdata(s_tdata), .sTvalid(s_tvalid), .sTlast(s_tlast), .sTready(s_tready),
    .mTdata(m_tdata), .mTvalid(m_tvalid), .mTlast(m_tlast), .mTready(m_tready),
    .grantId(grant_id), .busy(busy), .timeoutErr(timeout_err), .timeoutClr(timeout_clr),
    .dbgState(dbg_state)
`ifdef AURORA_TX_ARB_STATS_EN
    , .pktCount(pkt_count)
`endif
  );

  // Source model: per-requester beat memory {last, data}
  logic [32:0]    src_mem [NREQ][256];
  int             src_head [NREQ];
  int             src_tail [NREQ];
  int             src_sidx [NREQ];
  int             gap [NREQ];
  int             gap_force [NREQ];
  int             exp_pkts [NREQ];
  int             max_gap;
  bit             rdy_rand;
  bit             rdy_q[$];
  logic [W-1:0]   exp_q[$];
  int             beat_cyc[$];
  int             model_ptr;
  int             cyc;
  bit             prev_last;
  int             n_total;
  int             n_pass;
  int             start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [W-1:0] beat(input logic [NREQ-1:0] mask, input int id,
                                        input logic last, input logic [31:0] data);
    return {mask, ID_WIDTH'(id), last, data};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0; src_tail[i] = 0; src_sidx[i] = 0;
      gap[i] = 0; gap_force[i] = 0; exp_pkts[i] = 0;
    end
    exp_q.delete();
    beat_cyc.delete();
    rdy_q.delete();
    model_ptr = 0;
    prev_last = 1'b0;
    max_gap   = 0;
    rdy_rand  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    m_tready = 1'b0; timeout_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic load_pkt(input int r, input int len, input logic [31:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      src_mem[r][src_tail[r]] = {(k == len - 1), (rnd ? 32'($urandom()) : base + 32'(k))};
      src_tail[r]++;
    end
  endtask

  // Round-robin at packet granularity over whatever packets are still unscheduled.
  function automatic void schedule();
    int w;
    logic [32:0] b;
    do begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && src_sidx[(model_ptr + k) % NREQ] < src_tail[(model_ptr + k) % NREQ])
          w = (model_ptr + k) % NREQ;
      if (w >= 0) begin
        do begin
          b = src_mem[w][src_sidx[w]];
          src_sidx[w]++;
          exp_q.push_back(beat(NREQ'(1 << w), w, b[32], b[31:0]));
        end while (!b[32]);
        model_ptr = (w + 1) % NREQ;
        exp_pkts[w]++;
      end
    end while (w >= 0);
  endfunction

  task automatic cycle();
    logic [W-1:0]    obs;
    logic [W-1:0]    exp_v;
    logic [NREQ-1:0] acc;
    for (int i = 0; i < NREQ; i++) begin
      if (src_head[i] < src_tail[i] && gap[i] == 0) begin
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = src_mem[i][src_head[i]][32];
        s_tdata[32*i +: 32] = src_mem[i][src_head[i]][31:0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[32*i +: 32] = 32'h0;
      end
    end
    if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
    else if (rdy_rand)    m_tready = ($urandom_range(0, 3) != 0);
    else                  m_tready = 1'b1;
    #1;
    if (prev_last) check("bubble_after_tlast", m_tvalid, 0);
    prev_last = 1'b0;
    if (!m_tready) check("sready_under_backpressure", s_tready, 0);
    if (m_tvalid && m_tready) begin
      check("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        obs   = {s_tready, grant_id, m_tlast, m_tdata};
        exp_v = exp_q.pop_front();
        check("beat", obs, exp_v);
      end
      beat_cyc.push_back(cyc);
      prev_last = m_tlast;
    end
    acc = s_tvalid & s_tready;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (src_mem[i][src_head[i]][32]) gap[i] = 0;
        else if (gap_force[i] > 0) begin gap[i] = gap_force[i]; gap_force[i] = 0; end
        else gap[i] = $urandom_range(0, max_gap);
        src_head[i]++;
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_within_budget", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    n_total = 0; n_pass = 0; cyc = 0;
    clear_model();
    do_reset();

    // Reset state
    check("rst_mtvalid", m_tvalid, 0);
    check("rst_stready", s_tready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_mtdata", m_tdata, 0);

    // Req0 3-beat packet: one-cycle grant latency, back-to-back beats, then a bubble
    load_pkt(0, 3, 32'h10, 1'b0);
    schedule();
    start = cyc;
    run_until_done(20);
    check("t1_first_beat_latency", beat_cyc[0] - start, 1);
    check("t1_last_beat_cycle", beat_cyc[2] - start, 3);

    // All four requesters, two 2-beat packets each: 0,1,2,3,0,1,2,3 at 3 cycles/packet
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NREQ; r++) load_pkt(r, 2, 32'h100 * (r + 1) + 32'h10 * p, 1'b0);
    schedule();
    start = cyc;
    run_until_done(60);
    check("t2_total_cycles", beat_cyc[beat_cyc.size()-1] - start, 23);
    check("t2_timeout_err", timeout_err, 0);

    // Req1 with mTready toggling mid-packet
    do_reset();
    load_pkt(1, 4, 32'h20, 1'b0);
    schedule();
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b1);
    run_until_done(20);

    // Req2 stalls after beat 0: abort beat, sticky error, remainder as a new packet
    do_reset();
    load_pkt(2, 2, 32'hA0, 1'b0);
    src_sidx[2] = 2;
    gap_force[2] = 12;
    exp_q.push_back(beat(4'b0100, 2, 1'b0, 32'hA0));
    exp_q.push_back(beat(4'b0000, 2, 1'b1, ABORT_W));
    exp_q.push_back(beat(4'b0100, 2, 1'b1, 32'hA1));
    run_until_done(60);
    check("t4_abort_delay", beat_cyc[1] - beat_cyc[0], 9);
    check("t4_timeout_err_set", timeout_err, 1);
    timeout_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    timeout_clr = 1'b0;
    check("t4_timeout_err_cleared", timeout_err, 0);

    // Long backpressure mid-packet must not trip the watchdog
    do_reset();
    load_pkt(0, 3, 32'h30, 1'b0);
    schedule();
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    for (int k = 0; k < 5000; k++) rdy_q.push_back(1'b0);
    run_until_done(5100);
    check("t5_no_timeout", timeout_err, 0);

    // Reset mid-packet on req3
    do_reset();
    load_pkt(3, 4, 32'h40, 1'b0);
    schedule();
    cycle();
    cycle();
    check("t6_busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_in_reset_mtvalid", m_tvalid, 0);
    check("t6_in_reset_stready", s_tready, 0);
    check("t6_in_reset_mtdata", m_tdata, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    clear_model();
    #1;
    check("t6_after_reset_mtvalid", m_tvalid, 0);
    check("t6_after_reset_stready", s_tready, 0);
    check("t6_after_reset_grant", grant_id, 0);
`ifdef AURORA_TX_ARB_STATS_EN
    check("t6_pktcount_cleared", pkt_count, 0);
`endif
    load_pkt(3, 2, 32'h50, 1'b0);
    schedule();
    run_until_done(20);
`ifdef AURORA_TX_ARB_STATS_EN
    check("t6_pktcount3", pkt_count[16*3 +: 16], 1);
`endif

    // Randomized traffic: random lengths, data, mid-packet gaps and backpressure
    do_reset();
    max_gap  = 3;
    rdy_rand = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      int npk;
      npk = $urandom_range(2, 5);
      for (int p = 0; p < npk; p++) load_pkt(r, $urandom_range(1, 5), 32'h0, 1'b1);
    end
    schedule();
    run_until_done(3000);
    check("rand_timeout_err", timeout_err, 0);
`ifdef AURORA_TX_ARB_STATS_EN
    for (int r = 0; r < NREQ; r++)
      check("rand_pktcount", pkt_count[16*r +: 16], exp_pkts[r]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
